cpu_run_ctrl: RTL and testbench
===============================

// Module: cpu_run_ctrl
// PURPOSE
//  Run controller between the board clock/reset and the multicycle cpu core.
//  Holds the core in reset for a programmable number of cycles after reset
//  releases, then gates the core's clock enable for free-run, single-step or
//  bounded-cycle execution. Halts on PC breakpoints and counts executed cycles.
//  Generalises the fixed reset-then-free-clock bring-up flow into a reusable block.
// PARAMETERS
//  RST_HOLD  16  cycles cpu_rst_n stays low after reset deasserts (>=1)
//  CNT_W     32  width of cycle counter and cycle_limit
//  PC_W      32  width of program counter / breakpoint addresses
//  N_BP      2   number of breakpoint channels (1..8)
// PORTS
//  clk          in   1           system clock, rising edge
//  reset        in   1           asynchronous, active-low reset
//  mode         in   2           00 free-run, 01 single-step, 10 bounded, 11 = halt
//  step         in   1           level; rising edge requests one core cycle (mode 01)
//  resume       in   1           level; rising edge leaves HALT
//  cycle_limit  in   CNT_W       enabled-cycle budget for mode 10
//  pc           in   PC_W        current core PC, sampled every cycle
//  bp_en        in   N_BP        per-channel breakpoint enable
//  bp_addr      in   N_BP*PC_W   channel i at [i*PC_W +: PC_W]
//  cpu_rst_n    out  1           active-low reset to core (registered)
//  cpu_ce       out  1           core clock enable (registered)
//  cycle_cnt    out  CNT_W       count of cycles with cpu_ce=1 since hold ended
//  halted       out  1           1 while in HALT
//  halt_cause   out  2           00 none, 01 mode 11, 10 limit, 11 breakpoint
//  bp_hit_idx   out  3           lowest-index channel that matched on last bp halt
// BEHAVIOUR
//  Reset (reset=0): state=HOLD, cpu_rst_n=0, cpu_ce=0, cycle_cnt=0, halted=0,
//   halt_cause=00, bp_hit_idx=0, hold counter=0, step/resume edge regs=0.
//  Edge detect: step_p = step & ~step_q; resume_p = resume & ~resume_q (1-cycle).
//  HOLD: counter increments; when counter==RST_HOLD-1 -> cpu_rst_n=1 next cycle,
//   go RUN (mode 00/10), STEPWAIT (01) or HALT cause 01 (11).
//   cpu_rst_n therefore first high RST_HOLD cycles after reset release edge.
//  RUN: cpu_ce=1 each cycle; cycle_cnt += 1 per cycle cpu_ce=1, wraps at 2^CNT_W.
//   Exit priority (evaluated on registered values, highest first):
//   1) breakpoint: any i with bp_en[i] && pc==bp_addr[i] -> HALT, cause 11,
//      bp_hit_idx=lowest such i; cpu_ce=0 from next cycle (the matching
//      instruction's cycle is not enabled).
//   2) mode==11 -> HALT cause 01.   3) mode==01 -> STEPWAIT.
//   4) mode==10 && cycle_cnt+1 >= cycle_limit -> HALT cause 10 after that
//      enabled cycle; cycle_limit==0 -> HALT immediately, no enabled cycle.
//  STEPWAIT: cpu_ce=0; on step_p -> exactly one cycle cpu_ce=1, then back to
//   STEPWAIT; breakpoint checked before the step is granted (match -> HALT 11).
//   mode change to 00/10 -> RUN; 11 -> HALT cause 01.
//  HALT: cpu_ce=0, halted=1. resume_p with mode!=11 -> RUN/STEPWAIT per mode,
//   halt_cause->00, halted->0; breakpoint re-arm: first resumed cycle ignores a
//   match at the halted PC so execution advances. resume_p with mode 11 ignored.
//   cycle_cnt holds; mode 10 after limit halt needs cycle_limit raised or
//   cycle_cnt cleared by reset, else halts again immediately (cause 10).
//  Simultaneous step_p and breakpoint: breakpoint wins, step dropped.
//  Reset mid-operation: all state returns to HOLD instantly (asynchronous);
//   cpu_rst_n drops in the same instant, full RST_HOLD sequence repeats.
//  All outputs registered; no combinational input->output path.
// TESTING
//  T1 reset low 5 cyc, release, mode=00 -> cpu_rst_n rises exactly 16 cycles
//     after release, cpu_ce=1 next, cycle_cnt=10 after 10 enabled cycles.
//  T2 mode=01, 3 step pulses spaced 4 cycles -> exactly 3 single-cycle cpu_ce
//     pulses, cycle_cnt=3; holding step high 20 cycles gives only 1 pulse.
//  T3 mode=10, cycle_limit=25 -> 25 enabled cycles, halted=1, halt_cause=10.
//  T4 bp_en=2'b10, bp_addr[1]=0x0000_0040, pc driven to 0x40 -> halted=1,
//     cause 11, bp_hit_idx=1; resume pulse -> runs past 0x40 without re-halt.
//  T5 both channels =0x20, pc=0x20 while step_p asserted -> bp_hit_idx=0, no ce.
//  T6 reset pulled low during RUN -> cpu_rst_n=0, cpu_ce=0, cycle_cnt=0 at
//     once; after release full 16-cycle hold reoccurs.

Source files
------------

// File: rtl/cpu_run_ctrl.sv
// Run controller for the multicycle core: post-reset hold, then clock-enable gating
// for free-run, single-step and cycle-bounded execution, with PC breakpoints and a cycle counter.
module cpu_run_ctrl #(
  parameter int unsigned RST_HOLD = 16,
  parameter int unsigned CNT_W    = 32,
  parameter int unsigned PC_W     = 32,
  parameter int unsigned N_BP     = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [1:0]           mode_i,
  input  logic                 step_i,
  input  logic                 resume_i,
  input  logic [CNT_W-1:0]     cycle_limit_i,
  input  logic [PC_W-1:0]      pc_i,
  input  logic [N_BP-1:0]      bp_en_i,
  input  logic [N_BP*PC_W-1:0] bp_addr_i,
  output logic                 cpu_rst_no,
  output logic                 cpu_ce_o,
  output logic [CNT_W-1:0]     cycle_cnt_o,
  output logic                 halted_o,
  output logic [1:0]           halt_cause_o,
  output logic [2:0]           bp_hit_idx_o
);

  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  localparam logic [1:0] MODE_FREE  = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BOUND = 2'b10;
  localparam logic [1:0] MODE_HALT  = 2'b11;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_MODE  = 2'b01;
  localparam logic [1:0] CAUSE_LIMIT = 2'b10;
  localparam logic [1:0] CAUSE_BP    = 2'b11;

  typedef enum logic [1:0] {
    S_HOLD     = 2'd0,
    S_RUN      = 2'd1,
    S_STEPWAIT = 2'd2,
    S_HALT     = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              cpu_rst_n_q, cpu_rst_n_d;
  logic              cpu_ce_q, cpu_ce_d;
  logic [CNT_W-1:0]  cycle_cnt_q, cycle_cnt_d;
  logic              halted_q, halted_d;
  logic [1:0]        halt_cause_q, halt_cause_d;
  logic [2:0]        bp_hit_idx_q, bp_hit_idx_d;
  logic              bp_ign_q, bp_ign_d;
  logic              step_q, resume_q;

  logic              step_p, resume_p;
  logic              bp_any, bp_live;
  logic [2:0]        bp_idx;
  logic              grant;
  logic              halt_req;
  logic [1:0]        halt_req_cause;

  assign step_p   = step_i & ~step_q;
  assign resume_p = resume_i & ~resume_q;

  // Walk channels high to low so the lowest matching index is the one left standing.
  always_comb begin
    bp_any = 1'b0;
    bp_idx = 3'd0;
    for (int i = N_BP - 1; i >= 0; i--) begin
      if (bp_en_i[i] && (pc_i == bp_addr_i[i*PC_W +: PC_W])) begin
        bp_any = 1'b1;
        bp_idx = 3'(i);
      end
    end
  end

  // The first decision after a resume skips the breakpoint so the core can leave the halted PC.
  assign bp_live = bp_any & ~bp_ign_q;

  always_comb begin
    state_d        = state_q;
    hold_cnt_d     = hold_cnt_q;
    cpu_rst_n_d    = cpu_rst_n_q;
    cpu_ce_d       = 1'b0;
    cycle_cnt_d    = cycle_cnt_q;
    halted_d       = halted_q;
    halt_cause_d   = halt_cause_q;
    bp_hit_idx_d   = bp_hit_idx_q;
    bp_ign_d       = bp_ign_q;
    grant          = 1'b0;
    halt_req       = 1'b0;
    halt_req_cause = CAUSE_NONE;

    unique case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          cpu_rst_n_d = 1'b1;
          unique case (mode_i)
            MODE_HALT: begin
              halt_req       = 1'b1;
              halt_req_cause = CAUSE_MODE;
            end
            MODE_STEP: state_d = S_STEPWAIT;
            default:   state_d = S_RUN;
          endcase
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end

      S_RUN: begin
        if (bp_live) begin
          halt_req       = 1'b1;
          halt_req_cause = CAUSE_BP;
          bp_hit_idx_d   = bp_idx;
        end else if (mode_i == MODE_HALT) begin
          halt_req       = 1'b1;
          halt_req_cause = CAUSE_MODE;
        end else if (mode_i == MODE_STEP) begin
          state_d = S_STEPWAIT;
        end else if ((mode_i == MODE_BOUND) && (cycle_cnt_q >= cycle_limit_i)) begin
          halt_req       = 1'b1;
          halt_req_cause = CAUSE_LIMIT;
        end else begin
          grant = 1'b1;
        end
      end

      S_STEPWAIT: begin
        if (step_p && bp_live) begin
          halt_req       = 1'b1;
          halt_req_cause = CAUSE_BP;
          bp_hit_idx_d   = bp_idx;
        end else if (mode_i == MODE_HALT) begin
          halt_req       = 1'b1;
          halt_req_cause = CAUSE_MODE;
        end else if ((mode_i == MODE_FREE) || (mode_i == MODE_BOUND)) begin
          state_d = S_RUN;
        end else if (step_p) begin
          grant = 1'b1;
        end
      end

      S_HALT: begin
        if (resume_p && (mode_i != MODE_HALT)) begin
          state_d      = (mode_i == MODE_STEP) ? S_STEPWAIT : S_RUN;
          halted_d     = 1'b0;
          halt_cause_d = CAUSE_NONE;
          bp_ign_d     = 1'b1;
        end
      end

      default: state_d = S_HOLD;
    endcase

    if (halt_req) begin
      state_d      = S_HALT;
      halted_d     = 1'b1;
      halt_cause_d = halt_req_cause;
    end

    if (grant) begin
      cpu_ce_d    = 1'b1;
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
      bp_ign_d    = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_HOLD;
      hold_cnt_q   <= '0;
      cpu_rst_n_q  <= 1'b0;
      cpu_ce_q     <= 1'b0;
      cycle_cnt_q  <= '0;
      halted_q     <= 1'b0;
      halt_cause_q <= CAUSE_NONE;
      bp_hit_idx_q <= 3'd0;
      bp_ign_q     <= 1'b0;
      step_q       <= 1'b0;
      resume_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      cpu_rst_n_q  <= cpu_rst_n_d;
      cpu_ce_q     <= cpu_ce_d;
      cycle_cnt_q  <= cycle_cnt_d;
      halted_q     <= halted_d;
      halt_cause_q <= halt_cause_d;
      bp_hit_idx_q <= bp_hit_idx_d;
      bp_ign_q     <= bp_ign_d;
      step_q       <= step_i;
      resume_q     <= resume_i;
    end
  end

  assign cpu_rst_no   = cpu_rst_n_q;
  assign cpu_ce_o     = cpu_ce_q;
  assign cycle_cnt_o  = cycle_cnt_q;
  assign halted_o     = halted_q;
  assign halt_cause_o = halt_cause_q;
  assign bp_hit_idx_o = bp_hit_idx_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed bring-up scenarios followed by random traffic,
// every cycle scored against a behavioural model through an expectation queue.
module tb_cpu_run_ctrl;
  localparam int RST_HOLD = 16;
  localparam int CNT_W    = 32;
  localparam int PC_W     = 32;
  localparam int N_BP     = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic [1:0]           mode;
  logic                 step, resume;
  logic [CNT_W-1:0]     limit;
  logic [PC_W-1:0]      pc;
  logic [N_BP-1:0]      bp_en;
  logic [N_BP*PC_W-1:0] bp_addr;
  logic                 cpu_rst_n, cpu_ce, halted;
  logic [CNT_W-1:0]     cnt;
  logic [1:0]           cause;
  logic [2:0]           idx;

  cpu_run_ctrl #(.RST_HOLD(RST_HOLD), .CNT_W(CNT_W), .PC_W(PC_W), .N_BP(N_BP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .step_i(step), .resume_i(resume),
    .cycle_limit_i(limit), .pc_i(pc), .bp_en_i(bp_en), .bp_addr_i(bp_addr),
    .cpu_rst_no(cpu_rst_n), .cpu_ce_o(cpu_ce), .cycle_cnt_o(cnt), .halted_o(halted),
    .halt_cause_o(cause), .bp_hit_idx_o(idx)
  );

  typedef struct packed {
    logic             rstn;
    logic             ce;
    logic [CNT_W-1:0] cnt;
    logic             halted;
    logic [1:0]       cause;
    logic [2:0]       idx;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  event async_ev;

  // Behavioural model: "released", "halted" and "stepping" describe what the core is allowed to do.
  int               m_hold_left;
  logic             m_released, m_ce, m_halted, m_stepping, m_skip, m_pstep, m_presume;
  logic [1:0]       m_cause;
  logic [2:0]       m_idx;
  logic [CNT_W-1:0] m_cnt;
  logic [PC_W-1:0]  m_pc;

  task automatic model_reset();
    m_hold_left = RST_HOLD;
    m_released = 1'b0; m_ce = 1'b0; m_halted = 1'b0; m_stepping = 1'b0; m_skip = 1'b0;
    m_pstep = 1'b0; m_presume = 1'b0; m_cause = 2'd0; m_idx = 3'd0; m_cnt = '0;
    m_pc = '0;
  endtask

  task automatic push_exp();
    exp_t e;
    e.rstn = m_released; e.ce = m_ce; e.cnt = m_cnt;
    e.halted = m_halted; e.cause = m_cause; e.idx = m_idx;
    exp_q.push_back(e);
  endtask

  task automatic model_step();
    logic rise_step, rise_resume;
    int   hit;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rise_step   = step & ~m_pstep;
    rise_resume = resume & ~m_presume;
    m_pstep     = step;
    m_presume   = resume;
    m_ce        = 1'b0;
    m_pc        = pc;
    hit = -1;
    if (!m_skip)
      for (int i = 0; i < N_BP; i++)
        if (hit < 0 && bp_en[i] && pc == bp_addr[i*PC_W +: PC_W]) hit = i;

    if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) begin
        m_released = 1'b1;
        if (mode == 2'd3) begin m_halted = 1'b1; m_cause = 2'd1; end
        else m_stepping = (mode == 2'd1);
      end
    end else if (m_halted) begin
      if (rise_resume && mode != 2'd3) begin
        m_halted = 1'b0; m_cause = 2'd0; m_skip = 1'b1;
        m_stepping = (mode == 2'd1);
      end
    end else if (!m_stepping) begin
      if (hit >= 0) begin m_halted = 1'b1; m_cause = 2'd3; m_idx = 3'(hit); end
      else if (mode == 2'd3) begin m_halted = 1'b1; m_cause = 2'd1; end
      else if (mode == 2'd1) m_stepping = 1'b1;
      else if (mode == 2'd2 && m_cnt >= limit) begin m_halted = 1'b1; m_cause = 2'd2; end
      else m_ce = 1'b1;
    end else begin
      if (rise_step && hit >= 0) begin m_halted = 1'b1; m_cause = 2'd3; m_idx = 3'(hit); end
      else if (mode == 2'd3) begin m_halted = 1'b1; m_cause = 2'd1; end
      else if (mode != 2'd1) m_stepping = 1'b0;
      else if (rise_step) m_ce = 1'b1;
    end

    if (m_ce) begin
      m_cnt  = m_cnt + 1'b1;
      m_skip = 1'b0;
      m_pc   = pc + 32'd4;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    push_exp();
    @(negedge clk);
    #1;
    pc = m_pc;
  endtask

  task automatic async_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    push_exp();
    -> async_ev;
    #1;
  endtask

  task automatic pulse_resume();
    resume = 1'b1; tick(); resume = 1'b0; tick();
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk or async_ev);
      while (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("cpu_rst_n",  64'(cpu_rst_n), 64'(mon_e.rstn));
        chk("cpu_ce",     64'(cpu_ce),    64'(mon_e.ce));
        chk("cycle_cnt",  64'(cnt),       64'(mon_e.cnt));
        chk("halted",     64'(halted),    64'(mon_e.halted));
        chk("halt_cause", 64'(cause),     64'(mon_e.cause));
        chk("bp_hit_idx", 64'(idx),       64'(mon_e.idx));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    rst_n = 1'b0; mode = 2'd0; step = 1'b0; resume = 1'b0;
    limit = '0; pc = '0; bp_en = '0; bp_addr = '0;

    // Bring-up in free-run
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (RST_HOLD + 12) tick();

    // Single-step pulses, then a held step level
    mode = 2'd1;
    repeat (4) tick();
    repeat (3) begin step = 1'b1; tick(); step = 1'b0; repeat (3) tick(); end
    step = 1'b1; repeat (20) tick(); step = 1'b0; repeat (3) tick();

    // Bounded run from a fresh reset, re-halt on stale limit, then a raised limit
    rst_n = 1'b0; repeat (2) tick();
    rst_n = 1'b1; mode = 2'd2; limit = 32'd25;
    repeat (RST_HOLD + 35) tick();
    pulse_resume(); repeat (3) tick();
    limit = 32'd30; pulse_resume(); repeat (10) tick();

    // Breakpoint on channel 1, then resume past it
    mode = 2'd0; pc = '0; bp_en = 2'b10;
    bp_addr = {32'h0000_0040, 32'h0000_1000};
    pulse_resume(); repeat (25) tick();
    pulse_resume(); repeat (10) tick();
    bp_en = 2'b00;

    // Both channels match while a step is requested
    mode = 2'd1; repeat (3) tick();
    bp_en = 2'b11; bp_addr = {32'h0000_0020, 32'h0000_0020}; pc = 32'h20;
    step = 1'b1; tick(); step = 1'b0; repeat (4) tick();
    pulse_resume(); step = 1'b1; tick(); step = 1'b0; repeat (3) tick();
    bp_en = 2'b00;

    // Asynchronous reset while running
    mode = 2'd0; pulse_resume(); repeat (10) tick();
    async_reset();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (RST_HOLD + 6) tick();

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      step   = ($urandom_range(0, 3) == 0);
      resume = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 39) == 0) limit = m_cnt + 32'($urandom_range(0, 40));
      if ($urandom_range(0, 29) == 0) begin
        bp_en   = 2'($urandom_range(0, 3));
        bp_addr = {pc + 32'(4 * $urandom_range(0, 8)), pc + 32'(4 * $urandom_range(0, 8))};
      end
      if ($urandom_range(0, 99) == 0) pc = 32'(4 * $urandom_range(0, 64));
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
        repeat ($urandom_range(1, 3)) tick();
        rst_n = 1'b1;
      end
      tick();
    end

    step = 1'b0; resume = 1'b0;
    repeat (2) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
